mem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the 4K x 16 single-port memory model. It takes independent request/done handshakes from two masters, port 0 (instruction fetch) and port 1 (data load/store). It grants them round-robin, drives the memory's select/valid protocol and returns read data with a one-cycle done pulse. It sits between the S1 core's bus units and the memory, and is the only driver of the memory's select, address, write-data and write-enable inputs.

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter and access sequencer for the 4K x 16 single-port memory.
// Define MEM_ARB_TIMEOUT_EN to build the BUSY-state watchdog that aborts accesses after TO_CYCLES.
module mem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 16,
    parameter int TO_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inputReq0,
    input  logic              inputReq1,
    input  logic [ADDR_W-1:0] inputAddr0,
    input  logic [ADDR_W-1:0] inputAddr1,
    input  logic [DATA_W-1:0] inputWdata0,
    input  logic [DATA_W-1:0] inputWdata1,
    input  logic              inputWnR0,
    input  logic              inputWnR1,
    output logic [1:0]        outputDone,
    output logic [DATA_W-1:0] outputRdata,
    output logic              outputError,
    output logic              outputBusy,
    output logic              outputMemSelect,
    output logic [ADDR_W-1:0] outputMemAddress,
    output logic [DATA_W-1:0] outputMemWdata,
    output logic              outputMemWnR,
    input  logic [DATA_W-1:0] inputMemRdata,
    input  logic              inputMemValid
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_ptr;
    logic                r_grant;
    logic                r_select;
    logic                r_busy;
    logic                r_wnr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                w_any_req;
    logic                w_win;
    logic                w_grant_en;
    logic                w_finish;
    logic                w_timeout;

    if (TO_CYCLES < 2 || TO_CYCLES > 255) begin : g_bad_to_cycles
        $error("mem_arbiter: TO_CYCLES must be in 2..255");
    end

    assign w_any_req = inputReq0 | inputReq1;
    // On a tie the port that did not win last time goes next.
    assign w_win     = (inputReq0 & inputReq1) ? ~r_ptr : inputReq1;

    always_comb begin
        w_next_state = r_state;
        w_grant_en   = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_grant_en   = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (inputMemValid || w_timeout) begin
                    w_finish     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= 1'b1;
            r_grant  <= 1'b0;
            r_select <= 1'b0;
            r_busy   <= 1'b0;
            r_wnr    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_grant_en) begin
            r_ptr    <= w_win;
            r_grant  <= w_win;
            r_select <= 1'b1;
            r_busy   <= 1'b1;
            r_wnr    <= w_win ? inputWnR1   : inputWnR0;
            r_addr   <= w_win ? inputAddr1  : inputAddr0;
            r_wdata  <= w_win ? inputWdata1 : inputWdata0;
        end else if (w_finish) begin
            // Address/data/wnr stay as they were; only the select handshake drops.
            r_select <= 1'b0;
            r_busy   <= 1'b0;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

    logic [7:0] r_to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_grant_en) begin
            r_to_cnt <= '0;
        end else if (r_state == BUSY) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    // A valid pulse in the expiry cycle is a normal completion.
    assign w_timeout = (r_state == BUSY) && !inputMemValid && (r_to_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    assign outputDone       = w_finish ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
    assign outputRdata      = (w_finish && inputMemValid && !r_wnr) ? inputMemRdata : '0;
    assign outputError      = w_timeout;
    assign outputBusy       = r_busy;
    assign outputMemSelect  = r_select;
    assign outputMemAddress = r_addr;
    assign outputMemWdata   = r_wdata;
    assign outputMemWnR     = r_wnr;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and scoreboard bench for mem_arbiter with a behavioural 4K x 16 memory.
module tb_mem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_CYCLES = 4;
`else
    localparam int TO_CYCLES = 16;
`endif

    logic              clk;
    logic              rst;
    logic              inputReq0, inputReq1;
    logic [ADDR_W-1:0] inputAddr0, inputAddr1;
    logic [DATA_W-1:0] inputWdata0, inputWdata1;
    logic              inputWnR0, inputWnR1;
    logic [1:0]        outputDone;
    logic [DATA_W-1:0] outputRdata;
    logic              outputError;
    logic              outputBusy;
    logic              outputMemSelect;
    logic [ADDR_W-1:0] outputMemAddress;
    logic [DATA_W-1:0] outputMemWdata;
    logic              outputMemWnR;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              mem_stall;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .TO_CYCLES (TO_CYCLES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .inputReq0        (inputReq0),
        .inputReq1        (inputReq1),
        .inputAddr0       (inputAddr0),
        .inputAddr1       (inputAddr1),
        .inputWdata0      (inputWdata0),
        .inputWdata1      (inputWdata1),
        .inputWnR0        (inputWnR0),
        .inputWnR1        (inputWnR1),
        .outputDone       (outputDone),
        .outputRdata      (outputRdata),
        .outputError      (outputError),
        .outputBusy       (outputBusy),
        .outputMemSelect  (outputMemSelect),
        .outputMemAddress (outputMemAddress),
        .outputMemWdata   (outputMemWdata),
        .outputMemWnR     (outputMemWnR),
        .inputMemRdata    (mem_rdata),
        .inputMemValid    (mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: captures on select, answers with a one-cycle valid pulse the next cycle.
    logic [DATA_W-1:0] mem [4096];
    int                n_mem_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid <= 1'b0;
            mem_rdata <= '0;
            n_mem_acc <= 0;
            for (int i = 0; i < 4096; i++)
                mem[i] <= (i == 10) ? 16'h1234 : (16'hA000 | 16'(i));
        end else begin
            mem_valid <= 1'b0;
            if (outputMemSelect && !mem_valid && !mem_stall) begin
                mem_valid <= 1'b1;
                n_mem_acc <= n_mem_acc + 1;
                if (outputMemWnR) begin
                    mem[outputMemAddress] <= outputMemWdata;
                    mem_rdata <= 16'h5A5A;
                end else begin
                    mem_rdata <= mem[outputMemAddress];
                end
            end
        end
    end

    logic [DATA_W-1:0] shadow [4096];

    typedef struct {
        logic [1:0]  done;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        int          port;
        logic        wnr;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    int   cyc_now  = 0;
    int   td0[$];
    int   td1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Done monitor and select-after-valid watcher, sampled on the falling edge.
    initial begin
        exp_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc_now++;
            if (prev_valid) begin
                n_checks++;
                if (outputMemSelect !== 1'b0) begin
                    n_errors++;
                    $display("FAIL sel_after_valid: select=%b expected 0", outputMemSelect);
                end
            end
            prev_valid = mem_valid;
            if (outputDone != 2'b00) begin
                n_done++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_done: done=%b with empty scoreboard", outputDone);
                end else begin
                    e = sb.pop_front();
                    if (outputDone !== e.done || outputRdata !== e.rdata || outputError !== e.err) begin
                        n_errors++;
                        $display("FAIL done_pulse: done=%b rdata=%h err=%b expected done=%b rdata=%h err=%b",
                                 outputDone, outputRdata, outputError, e.done, e.rdata, e.err);
                    end
                end
            end
        end
    end

    // Called and returns at posedge+1; lat counts cycles from request to done.
    task automatic do_access(input int port, input logic wnr, input logic [11:0] addr,
                             input logic [15:0] wdata, input logic [15:0] exp_rd,
                             input logic exp_err, output int lat);
        exp_t e;
        e.done  = (port == 1) ? 2'b10 : 2'b01;
        e.rdata = wnr ? 16'h0000 : exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        if (port == 1) begin
            inputAddr1 = addr; inputWdata1 = wdata; inputWnR1 = wnr; inputReq1 = 1'b1;
        end else begin
            inputAddr0 = addr; inputWdata0 = wdata; inputWnR0 = wnr; inputReq0 = 1'b1;
        end
        lat = 0;
        forever begin
            @(negedge clk);
            if (outputDone[port]) break;
            @(posedge clk); #1;
            lat++;
            if (lat > 200) begin
                check("access_bound", 64'(lat), 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        if (port == 1) inputReq1 = 1'b0;
        else           inputReq0 = 1'b0;
        if (wnr && !exp_err) shadow[addr] = wdata;
    endtask

    // Both ports request reads continuously until n completions; grants alternate.
    task automatic run_both(input logic [11:0] a0, input logic [11:0] a1, input int n, input int first);
        exp_t e;
        int   got;
        int   cyc;
        int   p;
        td0.delete();
        td1.delete();
        for (int k = 0; k < n; k++) begin
            p       = (k + first) % 2;
            e.done  = (p == 1) ? 2'b10 : 2'b01;
            e.rdata = shadow[(p == 1) ? a1 : a0];
            e.err   = 1'b0;
            sb.push_back(e);
        end
        inputAddr0 = a0; inputWnR0 = 1'b0; inputWdata0 = 16'h1111;
        inputAddr1 = a1; inputWnR1 = 1'b0; inputWdata1 = 16'h2222;
        inputReq0 = 1'b1;
        inputReq1 = 1'b1;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            if (outputDone[0]) begin td0.push_back(cyc); got++; end
            if (outputDone[1]) begin td1.push_back(cyc); got++; end
            @(posedge clk); #1;
            cyc++;
        end
        inputReq0 = 1'b0;
        inputReq1 = 1'b0;
        check("both_count", 64'(got), 64'(n));
    endtask

    vec_t vecs[8];

    initial begin
        int lat;
        int acc0;
        int d0;

        vecs[0] = '{0, 1'b1, 12'h100, 16'hCAFE, 16'h0000};
        vecs[1] = '{1, 1'b0, 12'h100, 16'hDEAD, 16'hCAFE};
        vecs[2] = '{1, 1'b1, 12'h7FF, 16'h0F0F, 16'h0000};
        vecs[3] = '{0, 1'b0, 12'h7FF, 16'h0000, 16'h0F0F};
        vecs[4] = '{0, 1'b0, 12'h123, 16'h0000, 16'hA123};
        vecs[5] = '{1, 1'b1, 12'h001, 16'hFFFF, 16'h0000};
        vecs[6] = '{1, 1'b0, 12'h001, 16'h0000, 16'hFFFF};
        vecs[7] = '{0, 1'b0, 12'h100, 16'h0000, 16'hCAFE};

        for (int i = 0; i < 4096; i++)
            shadow[i] = (i == 10) ? 16'h1234 : (16'hA000 | 16'(i));

        mem_stall = 1'b0;
        rst = 1'b1;
        inputReq0 = 1'b0; inputReq1 = 1'b0;
        inputAddr0 = '0; inputAddr1 = '0;
        inputWdata0 = '0; inputWdata1 = '0;
        inputWnR0 = 1'b0; inputWnR1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {outputMemSelect, outputMemAddress, outputMemWdata, outputMemWnR,
                                outputDone, outputRdata, outputError, outputBusy}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single read of a preloaded word.
        do_access(0, 1'b0, 12'h00A, 16'h0000, 16'h1234, 1'b0, lat);
        check("single_read_latency", 64'(lat), 64'd2);

        // Port 1 write then read back at the top address.
        acc0 = n_mem_acc;
        do_access(1, 1'b1, 12'hFFF, 16'hBEEF, 16'h0000, 1'b0, lat);
        check("write_mem_accesses", 64'(n_mem_acc - acc0), 64'd1);
        acc0 = n_mem_acc;
        do_access(1, 1'b0, 12'hFFF, 16'h0000, 16'hBEEF, 1'b0, lat);
        check("read_mem_accesses", 64'(n_mem_acc - acc0), 64'd1);

        // Contention: last grant was port 1, so port 0 goes first.
        acc0 = n_mem_acc;
        run_both(12'h020, 12'h030, 4, 0);
        check("rr_count0", 64'(td0.size()), 64'd2);
        check("rr_count1", 64'(td1.size()), 64'd2);
        check("rr_period0", 64'(td0[1] - td0[0]), 64'd6);
        check("rr_period1", 64'(td1[1] - td1[0]), 64'd6);
        check("rr_first_gap", 64'(td1[0] - td0[0]), 64'd3);
        check("rr_mem_accesses", 64'(n_mem_acc - acc0), 64'd4);

        for (int i = 0; i < 8; i++) begin
            acc0 = n_mem_acc;
            do_access(vecs[i].port, vecs[i].wnr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 1'b0, lat);
            check("vec_latency", 64'(lat), 64'd2);
            check("vec_mem_accesses", 64'(n_mem_acc - acc0), 64'd1);
        end

        // Port 0 back-to-back reads with request held across accesses.
        d0 = n_done;
        for (int i = 0; i < 4; i++)
            do_access(0, 1'b0, 12'(i), 16'h0000, shadow[i], 1'b0, lat);
        check("held_done_count", 64'(n_done - d0), 64'd4);

`ifdef MEM_ARB_TIMEOUT_EN
        mem_stall = 1'b1;
        do_access(0, 1'b0, 12'h0AB, 16'h0000, 16'h0000, 1'b1, lat);
        mem_stall = 1'b0;
        check("timeout_latency", 64'(lat), 64'd4);
        @(posedge clk); #1;
        check("timeout_idle", 64'(outputBusy), 64'd0);
`endif

        // Reset in cycle 1 of a port 0 write.
        inputAddr0 = 12'h555; inputWdata0 = 16'hAAAA; inputWnR0 = 1'b1; inputReq0 = 1'b1;
        @(posedge clk); #1;
        check("mid_select", 64'(outputMemSelect), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_reset_outputs", {outputMemSelect, outputMemAddress, outputMemWdata, outputMemWnR,
                                    outputDone, outputRdata, outputError, outputBusy}, 64'd0);
        inputReq0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4096; i++)
            shadow[i] = (i == 10) ? 16'h1234 : (16'hA000 | 16'(i));
        run_both(12'h040, 12'h050, 2, 0);
        check("post_reset_first_port0", 64'(td0.size() == 1 && td1.size() == 1 && td0[0] < td1[0]), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

endmodule
